// File: rtl/icache_pkg.sv
// icache_pkg: shared state type and default geometry for the instruction cache
package icache_pkg;
  typedef enum logic {IDLE, REFILL} state_t;
  localparam int DEF_LINES = 16;
  localparam int DEF_WORDS = 4;
  localparam int DEF_IW = $clog2(DEF_LINES);
  localparam int DEF_OW = $clog2(DEF_WORDS);
  localparam int DEF_TW = 30 - DEF_IW - DEF_OW;
endpackage

// File: rtl/icache_ctrl.sv
// icache_ctrl: miss FSM, beat counter and miss-address latch driving the refill burst
module icache_ctrl import icache_pkg::*; #(
  parameter int IW = DEF_IW,
  parameter int OW = DEF_OW,
  parameter int TW = DEF_TW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_hit,
  input  logic [TW-1:0] i_tag,
  input  logic [IW-1:0] i_idx,
  input  logic          i_ready,
  output logic          o_stall,
  output logic          o_req,
  output logic [31:0]   o_addr,
  output logic          o_clr,
  output logic          o_we,
  output logic          o_fill,
  output logic [IW-1:0] o_idx,
  output logic [TW-1:0] o_tag,
  output logic [OW-1:0] o_beat
);
  state_t        r_state, w_state_n;
  logic [TW-1:0] r_mtag;
  logic [IW-1:0] r_midx;
  logic [OW-1:0] r_beat;
  // state register, beat counter and miss latch; latch fields are not reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_n;
      r_beat  <= o_clr ? '0 : o_we ? r_beat + 1'b1 : r_beat;
      if (o_clr) {r_mtag, r_midx} <= {i_tag, i_idx};
    end
  end
  // next state and outputs; everything is gated by reset so abandoned beats do nothing
  always_comb begin
    o_clr     = !rst && r_state == IDLE && !i_hit;
    o_req     = !rst && r_state == REFILL;
    o_we      = o_req && i_ready;
    o_fill    = o_we && r_beat == OW'((1 << OW) - 1);
    o_stall   = !rst && (r_state == REFILL || !i_hit);
    o_addr    = o_req ? {r_mtag, r_midx, r_beat, 2'b00} : 32'd0;
    o_idx     = r_state == IDLE ? i_idx : r_midx;
    o_tag     = r_mtag;
    o_beat    = r_beat;
    w_state_n = o_clr ? REFILL : o_fill ? IDLE : r_state;
  end
endmodule

// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache with burst line refill
module icache import icache_pkg::*; #(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] PCF,
  output logic [31:0] InstrF,
  output logic        ICacheStall,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic        MemReady,
  input  logic [31:0] MemRData
);
  localparam int IW = $clog2(LINES);
  localparam int OW = $clog2(WORDS);
  localparam int TW = 30 - IW - OW;
  logic [LINES-1:0] r_valid;
  logic [TW-1:0]    r_tag [LINES];
  logic [31:0]      r_data [LINES*WORDS];
  logic [TW-1:0]    w_tag, w_ftag;
  logic [IW-1:0]    w_idx, w_lidx;
  logic [OW-1:0]    w_off, w_beat;
  logic             w_hit, w_clr, w_we, w_fill;
  assign w_tag = PCF[31:2+IW+OW];
  assign w_idx = PCF[2+IW+OW-1:2+OW];
  assign w_off = PCF[2+OW-1:2];
  assign w_hit = r_valid[w_idx] && r_tag[w_idx] == w_tag;
  assign InstrF = (!Reset && !ICacheStall) ? r_data[{w_idx, w_off}] : 32'd0;
  icache_ctrl #(.IW(IW), .OW(OW), .TW(TW)) u_ctrl (
    .clk(CLK), .rst(Reset), .i_hit(w_hit), .i_tag(w_tag), .i_idx(w_idx),
    .i_ready(MemReady), .o_stall(ICacheStall), .o_req(MemReq), .o_addr(MemAddr),
    .o_clr(w_clr), .o_we(w_we), .o_fill(w_fill), .o_idx(w_lidx), .o_tag(w_ftag),
    .o_beat(w_beat)
  );
  // valid bits: cleared when a refill starts, set when its last beat lands
  always_ff @(posedge CLK) begin
    if (Reset) r_valid <= '0;
    else if (w_clr) r_valid[w_lidx] <= 1'b0;
    else if (w_fill) r_valid[w_lidx] <= 1'b1;
  end
  // tag and data arrays carry no reset
  always_ff @(posedge CLK) begin
    if (w_fill) r_tag[w_lidx] <= w_ftag;
    if (w_we) r_data[{w_lidx, w_beat}] <= MemRData;
  end
endmodule
